// File: rtl/mips_mem_pkg.sv
// Shared definitions for the instruction-fetch / load-store memory arbiter.
// Holds the default bus widths, the FSM state encoding and the port-owner
// enumeration. Optional feature macro: MEM_ARB_RR_EN (round-robin arbitration).
package mips_mem_pkg;
    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (fetch, load/store), the shared
// single-port memory and the arbiter.
//   slave  : arbiter side (takes requests and mem_rdata, drives grants,
//            valid pulses, read data, memory controls and busy)
//   master : requester/memory side (the mirror image)
interface mem_arbiter_if
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    // fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;
    // load/store port
    logic              ls_req;
    logic              ls_we;
    logic              ls_half;
    logic              ls_byte;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt;
    logic              ls_valid;
    logic [DATA_W-1:0] ls_rdata;
    // memory side
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_write_d;
    logic              mem_Eh;
    logic              mem_Eb;
    logic [DATA_W-1:0] mem_rdata;
    // status
    logic              busy;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_half, ls_byte, ls_addr,
               ls_wdata, mem_rdata,
        output if_gnt, if_valid, if_rdata, ls_gnt, ls_valid, ls_rdata,
               mem_addr, mem_wdata, mem_write_d, mem_Eh, mem_Eb, busy
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_half, ls_byte, ls_addr,
               ls_wdata, mem_rdata,
        input  if_gnt, if_valid, if_rdata, ls_gnt, ls_valid, ls_rdata,
               mem_addr, mem_wdata, mem_write_d, mem_Eh, mem_Eb, busy
    );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and load/store.
// Ports: if_req, ls_req (requests), last (port served last, only with
// MEM_ARB_RR_EN), pick_if / pick_ls (one-hot or zero winner).
// MEM_ARB_RR_EN defined  : contention goes to the port not served last.
// MEM_ARB_RR_EN undefined: load/store always beats fetch.
module mem_arb_pick
    import mips_mem_pkg::*;
(
    input  logic   if_req,
    input  logic   ls_req,
`ifdef MEM_ARB_RR_EN
    input  owner_t last,
`endif
    output logic   pick_if,
    output logic   pick_ls
);
    always_comb begin
        pick_if = 1'b0;
        pick_ls = 1'b0;
        if (if_req && ls_req) begin
`ifdef MEM_ARB_RR_EN
            pick_if = (last == OWN_LS);
            pick_ls = (last == OWN_IF);
`else
            pick_ls = 1'b1;
`endif
        end else begin
            pick_if = if_req;
            pick_ls = ls_req;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port memory with combinational read.
// IDLE grants one request and latches its command; ACCESS drives the memory
// for one cycle and registers the read data, the owner's valid pulses the
// cycle after. At most one transaction every two cycles.
// Ports: clk, rst (sync, active-high), bus (mem_arbiter_if.slave).
// Optional feature macro: MEM_ARB_RR_EN (round-robin instead of fixed
// load/store priority).
module mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    state_t            state, state_nx;
    owner_t            own;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              cmd_we, cmd_half, cmd_byte;
    logic              pick_if, pick_ls;
    logic              if_valid_r, ls_valid_r;
    logic [DATA_W-1:0] if_rdata_r, ls_rdata_r;
    logic [DATA_W-1:0] ld_data;
`ifdef MEM_ARB_RR_EN
    owner_t            last;
`endif

    mem_arb_pick u_pick (
        .if_req  (bus.if_req),
        .ls_req  (bus.ls_req),
`ifdef MEM_ARB_RR_EN
        .last    (last),
`endif
        .pick_if (pick_if),
        .pick_ls (pick_ls)
    );

    // Sub-word loads return the low byte/halfword zero-extended.
    always_comb begin
        ld_data = bus.mem_rdata;
        if (cmd_byte)      ld_data = DATA_W'(bus.mem_rdata[7:0]);
        else if (cmd_half) ld_data = DATA_W'(bus.mem_rdata[15:0]);
    end

    always_comb begin
        state_nx        = state;
        bus.if_gnt      = 1'b0;
        bus.ls_gnt      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        bus.mem_write_d = 1'b0;
        bus.mem_Eh      = 1'b0;
        bus.mem_Eb      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rst) begin
                    bus.if_gnt = pick_if;
                    bus.ls_gnt = pick_ls;
                    if (pick_if || pick_ls) state_nx = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                bus.mem_addr    = cmd_addr;
                bus.mem_wdata   = cmd_wdata;
                // A store caught by reset must not reach the memory.
                bus.mem_write_d = cmd_we & ~rst;
                bus.mem_Eh      = cmd_half | cmd_byte;
                bus.mem_Eb      = cmd_byte;
                state_nx        = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            own        <= OWN_LS;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            cmd_we     <= 1'b0;
            cmd_half   <= 1'b0;
            cmd_byte   <= 1'b0;
            if_valid_r <= 1'b0;
            ls_valid_r <= 1'b0;
            if_rdata_r <= '0;
            ls_rdata_r <= '0;
`ifdef MEM_ARB_RR_EN
            last       <= OWN_LS;
`endif
        end else begin
            state      <= state_nx;
            if_valid_r <= 1'b0;
            ls_valid_r <= 1'b0;
            if (bus.if_gnt) begin
                own       <= OWN_IF;
                cmd_addr  <= bus.if_addr;
                cmd_wdata <= '0;
                cmd_we    <= 1'b0;
                cmd_half  <= 1'b0;
                cmd_byte  <= 1'b0;
`ifdef MEM_ARB_RR_EN
                last      <= OWN_IF;
`endif
            end else if (bus.ls_gnt) begin
                own       <= OWN_LS;
                cmd_addr  <= bus.ls_addr;
                cmd_wdata <= bus.ls_wdata;
                cmd_we    <= bus.ls_we;
                // Stores are always full-word: drop the sub-word selects.
                cmd_half  <= bus.ls_half & ~bus.ls_we;
                cmd_byte  <= bus.ls_byte & ~bus.ls_we;
`ifdef MEM_ARB_RR_EN
                last      <= OWN_LS;
`endif
            end
            if (state == ST_ACCESS) begin
                if (own == OWN_IF) begin
                    if_rdata_r <= bus.mem_rdata;
                    if_valid_r <= 1'b1;
                end else begin
                    ls_rdata_r <= cmd_we ? '0 : ld_data;
                    ls_valid_r <= 1'b1;
                end
            end
        end
    end

    assign bus.if_valid = if_valid_r;
    assign bus.if_rdata = if_rdata_r;
    assign bus.ls_valid = ls_valid_r;
    assign bus.ls_rdata = ls_rdata_r;
    assign bus.busy     = (state == ST_ACCESS);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle-indexed transaction model
// (grant in N, access in N+1, valid in N+2) checked every cycle, plus
// hand-computed literal expectations for each scenario.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mips_mem_pkg::*;
    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int NCYC = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    // memory attached to the arbiter
    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) if (bus.mem_write_d) mem[bus.mem_addr] <= bus.mem_wdata;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- model ----------------
    typedef struct packed {
        logic          v;
        logic          ls;
        logic          we;
        logic          half;
        logic          byt;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } acc_t;

    acc_t          acc_q [0:NCYC-1];
    bit            vif_q [0:NCYC-1];
    bit            vls_q [0:NCYC-1];
    logic [DW-1:0] e_if_rd, e_ls_rd;
    bit            last_ls;
    acc_t          a;
    bit            w_if, w_ls;
    logic [DW-1:0] rd;

    initial begin
        for (int i = 0; i < NCYC; i++) begin
            acc_q[i] = '0; vif_q[i] = 1'b0; vls_q[i] = 1'b0;
        end
        e_if_rd = '0; e_ls_rd = '0; last_ls = 1'b1;
        forever begin
            @(negedge clk);
            a    = acc_q[cyc];
            w_if = 1'b0;
            w_ls = 1'b0;
            if (!rst && !a.v) begin
                if (bus.if_req && bus.ls_req) begin
`ifdef MEM_ARB_RR_EN
                    if (last_ls) w_if = 1'b1; else w_ls = 1'b1;
`else
                    w_ls = 1'b1;
`endif
                end else begin
                    w_if = bus.if_req;
                    w_ls = bus.ls_req;
                end
            end
            if (cyc >= 1) begin
                chk("if_gnt", DW'(bus.if_gnt), DW'(w_if));
                chk("ls_gnt", DW'(bus.ls_gnt), DW'(w_ls));
                chk("busy", DW'(bus.busy), DW'(a.v));
                chk("mem_addr", DW'(bus.mem_addr), a.v ? DW'(a.addr) : '0);
                chk("mem_write_d", DW'(bus.mem_write_d), DW'(a.v & a.ls & a.we & ~rst));
                chk("mem_Eh", DW'(bus.mem_Eh), DW'(a.v & a.ls & ~a.we & (a.half | a.byt)));
                chk("mem_Eb", DW'(bus.mem_Eb), DW'(a.v & a.ls & ~a.we & a.byt));
                if (!a.v || (a.ls && a.we))
                    chk("mem_wdata", bus.mem_wdata, a.v ? a.wdata : '0);
                chk("if_valid", DW'(bus.if_valid), DW'(vif_q[cyc]));
                chk("ls_valid", DW'(bus.ls_valid), DW'(vls_q[cyc]));
                chk("if_rdata", bus.if_rdata, e_if_rd);
                chk("ls_rdata", bus.ls_rdata, e_ls_rd);
            end
            // effect of the closing edge
            if (cyc + 1 < NCYC) begin
                if (rst) begin
                    e_if_rd = '0; e_ls_rd = '0; last_ls = 1'b1;
                end else begin
                    if (w_if) begin
                        acc_q[cyc+1]      = '0;
                        acc_q[cyc+1].v    = 1'b1;
                        acc_q[cyc+1].addr = bus.if_addr;
                        last_ls = 1'b0;
                    end
                    if (w_ls) begin
                        acc_q[cyc+1].v     = 1'b1;
                        acc_q[cyc+1].ls    = 1'b1;
                        acc_q[cyc+1].we    = bus.ls_we;
                        acc_q[cyc+1].half  = bus.ls_half;
                        acc_q[cyc+1].byt   = bus.ls_byte;
                        acc_q[cyc+1].addr  = bus.ls_addr;
                        acc_q[cyc+1].wdata = bus.ls_wdata;
                        last_ls = 1'b1;
                    end
                    if (a.v) begin
                        rd = ref_mem[a.addr];
                        if (!a.ls) begin
                            e_if_rd = rd;
                            vif_q[cyc+1] = 1'b1;
                        end else begin
                            vls_q[cyc+1] = 1'b1;
                            if (a.we) begin
                                e_ls_rd = '0;
                                ref_mem[a.addr] = a.wdata;
                            end else if (a.byt) e_ls_rd = {24'h0, rd[7:0]};
                            else if (a.half)    e_ls_rd = {16'h0, rd[15:0]};
                            else                e_ls_rd = rd;
                        end
                    end
                end
            end
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic ls_txn(input bit we, input bit half, input bit byt,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input logic [DW-1:0] exp, input string nm);
        int k;
        bus.ls_req = 1'b1; bus.ls_we = we; bus.ls_half = half; bus.ls_byte = byt;
        bus.ls_addr = addr; bus.ls_wdata = wd;
        k = 0;
        @(negedge clk);
        while (!bus.ls_gnt && k < 8) begin
            step(); @(negedge clk); k++;
        end
        chk({nm, "_gnt"}, DW'(bus.ls_gnt), 32'd1);
        step();
        bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_half = 1'b0; bus.ls_byte = 1'b0;
        step();
        @(negedge clk);
        chk({nm, "_valid"}, DW'(bus.ls_valid), 32'd1);
        chk({nm, "_rdata"}, bus.ls_rdata, exp);
        step();
    endtask

    logic [5:0] gi, gl;
    logic [4:0] bg, bv, bb;

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = 32'h5a000000 + i; ref_mem[i] = 32'h5a000000 + i;
        end
        mem[2]  = 32'h20230007; ref_mem[2]  = 32'h20230007;
        mem[20] = 32'h11111111; ref_mem[20] = 32'h11111111;
        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_half = 1'b0; bus.ls_byte = 1'b0;
        bus.ls_addr = '0; bus.ls_wdata = '0;
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", DW'(bus.busy), 32'd0);
        chk("rst_if_rdata", bus.if_rdata, 32'd0);
        chk("rst_ls_rdata", bus.ls_rdata, 32'd0);
        step();

        // fetch alone; a load/store request raised only during ACCESS is withdrawn
        bus.if_req = 1'b1; bus.if_addr = 10'd2;
        @(negedge clk); chk("f_gnt", DW'(bus.if_gnt), 32'd1);
        step(); bus.if_req = 1'b0; bus.ls_req = 1'b1; bus.ls_addr = 10'd5;
        @(negedge clk); chk("f_mem_addr", DW'(bus.mem_addr), 32'd2);
        step(); bus.ls_req = 1'b0;
        @(negedge clk);
        chk("f_valid", DW'(bus.if_valid), 32'd1);
        chk("f_rdata", bus.if_rdata, 32'h20230007);
        chk("wd_no_gnt", DW'(bus.ls_gnt), 32'd0);
        step();
        @(negedge clk); chk("wd_idle", DW'(bus.busy), 32'd0);
        step();

        // store, then word / byte / halfword / byte+half loads
        ls_txn(1'b1, 1'b0, 1'b0, 10'd12, 32'h909988ff, 32'h00000000, "st");
        ls_txn(1'b0, 1'b0, 1'b0, 10'd12, 32'h0,        32'h909988ff, "ldw");
        ls_txn(1'b0, 1'b0, 1'b1, 10'd12, 32'h0,        32'h000000ff, "ldb");
        ls_txn(1'b0, 1'b1, 1'b0, 10'd12, 32'h0,        32'h000088ff, "ldh");
        ls_txn(1'b0, 1'b1, 1'b1, 10'd12, 32'h0,        32'h000000ff, "ldhb");

        // contention right after reset
        rst = 1'b1; step(); rst = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 10'd2;
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 10'd12;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); gi[i] = bus.if_gnt; gl[i] = bus.ls_gnt; step();
        end
        bus.ls_req = 1'b0;
        @(negedge clk); chk("ct_if_after", DW'(bus.if_gnt), 32'd1);
        step(); bus.if_req = 1'b0;
`ifdef MEM_ARB_RR_EN
        chk("ct_if_pat", DW'(gi), 32'b010001);
        chk("ct_ls_pat", DW'(gl), 32'b000100);
`else
        chk("ct_if_pat", DW'(gi), 32'b000000);
        chk("ct_ls_pat", DW'(gl), 32'b010101);
`endif
        step(); step(); step();

        // back-to-back loads with ls_req held
        bus.ls_req = 1'b1; bus.ls_addr = 10'd12;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); bg[i] = bus.ls_gnt; bv[i] = bus.ls_valid; bb[i] = bus.busy; step();
        end
        bus.ls_req = 1'b0;
        chk("b2b_gnt", DW'(bg), 32'b10101);
        chk("b2b_valid", DW'(bv), 32'b10100);
        chk("b2b_busy", DW'(bb), 32'b01010);
        step(); step(); step();

        // reset during the ACCESS cycle of a store
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 10'd20; bus.ls_wdata = 32'hdeadbeef;
        @(negedge clk); chk("rs_gnt", DW'(bus.ls_gnt), 32'd1);
        step(); bus.ls_req = 1'b0; bus.ls_we = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rs_write_d", DW'(bus.mem_write_d), 32'd0);
        chk("rs_busy_acc", DW'(bus.busy), 32'd1);
        step(); rst = 1'b0;
        @(negedge clk);
        chk("rs_no_valid", DW'(bus.ls_valid), 32'd0);
        chk("rs_idle", DW'(bus.busy), 32'd0);
        chk("rs_mem20", mem[20], 32'h11111111);
        step(); step();

        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 10, word address width of the shared memory.
REQ-002 Parameter DATA_W, 32, data width of the shared memory.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 if_req  in  1  instruction-fetch read request, held until if_gnt.
REQ-006 if_addr  in  ADDR_W  fetch word address.
REQ-007 if_gnt  out  1  fetch request accepted this cycle.
REQ-008 if_valid  out  1  one-cycle pulse: if_rdata holds fetched word.
REQ-009 if_rdata  out  DATA_W  registered fetch data.
REQ-010 ls_req  in  1  load/store request, held until ls_gnt.
REQ-011 ls_we  in  1  1 = store word, 0 = load.
REQ-012 ls_half  in  1  halfword load.
REQ-013 ls_byte  in  1  byte load (valid alone or with ls_half).
REQ-014 ls_addr  in  ADDR_W  load/store word address.
REQ-015 ls_wdata  in  DATA_W  store data.
REQ-016 ls_gnt  out  1  load/store request accepted this cycle.
REQ-017 ls_valid  out  1  one-cycle pulse: load data in ls_rdata, or store committed.
REQ-018 ls_rdata  out  DATA_W  registered load data (0 for stores).
REQ-019 mem_addr / mem_wdata  out  ADDR_W / DATA_W  memory address and write data.
REQ-020 mem_write_d, mem_Eh, mem_Eb  out  1 each  memory write enable, halfword and byte select.
REQ-021 mem_rdata  in  DATA_W  combinational memory read data.
REQ-022 busy  out  1  high while FSM is in ACCESS.

Function
REQ-023 FSM states: IDLE, ACCESS; one transaction per two cycles maximum.
REQ-024 IDLE: if any req is high, assert exactly one gnt combinationally, latch that requester's command, go to ACCESS at next edge; else stay IDLE.
REQ-025 ACCESS: drive mem_* from latched command for exactly one cycle; at the closing edge load rdata register from mem_rdata, pulse the owner's valid in the following cycle, return to IDLE.
REQ-026 Latency: gnt in cycle N -> memory access in N+1 -> valid and rdata in N+2; IDLE in N+2 may grant a new request in the same cycle as valid.
REQ-027 Fetch access: mem_write_d=0, mem_Eh=0, mem_Eb=0.
REQ-028 Load: mem_Eh = ls_half|ls_byte, mem_Eb = ls_byte; result is zero-extended low 16/8 bits as returned by memory.
REQ-029 Store: mem_write_d=1, mem_Eh=0, mem_Eb=0, full word write; ls_rdata loads 0.
REQ-030 Outside ACCESS: mem_addr=0, mem_wdata=0, mem_write_d=0, mem_Eh=0, mem_Eb=0.
REQ-031 if_gnt and ls_gnt never both high; gnt never high outside IDLE or during rst.
REQ-032 Request dropped before gnt is treated as withdrawn, no transaction issued.
REQ-033 rdata registers of the non-owner hold their value.

Reset
REQ-034 rst high at an edge: FSM -> IDLE, gnt/valid/busy 0, if_rdata/ls_rdata 0, last-served marker -> load/store.
REQ-035 mem_write_d gated by ~rst combinationally: a store in ACCESS while rst is high is not written; no valid pulses for an aborted transaction.

Configuration
REQ-036 MEM_ARB_RR_EN defined: simultaneous requests in IDLE granted round-robin, to the port not served last; first contention after reset goes to fetch.
REQ-037 MEM_ARB_RR_EN undefined: fixed priority, load/store always wins over fetch; no last-served marker.

Structure
REQ-038 Shared package mips_mem_pkg: ADDR_W/DATA_W defaults, FSM state encoding constants, owner enumeration (OWN_IF, OWN_LS).
REQ-039 Sub-module mem_arb_pick: combinational winner selection (priority or round-robin), instantiated once.

Verification
REQ-040 Fetch alone: if_req=1, if_addr=2 in cycle 0 -> if_gnt cycle 0, mem_addr=2 cycle 1, if_valid cycle 2, if_rdata=32'h20230007.
REQ-041 Store then load: ls_we=1, ls_addr=12, ls_wdata=32'h909988ff; then load addr 12 -> ls_valid, ls_rdata=32'h909988ff.
REQ-042 Sub-word: load addr 12 with ls_byte=1 -> 32'h000000ff; ls_half=1 -> 32'h000088ff.
REQ-043 Contention: if_req and ls_req held high 6 cycles -> with MEM_ARB_RR_EN grants alternate IF, LS, IF; without it LS granted every transaction, IF only after ls_req drops.
REQ-044 Reset mid-store: rst=1 during ACCESS of store to addr 20 -> mem_write_d=0 that cycle, memory[20] unchanged, no ls_valid, FSM IDLE next cycle.
REQ-045 Back-to-back: ls_req held across valid -> new ls_gnt in same cycle as ls_valid, busy high every other cycle.
